pwm8_capture: RTL



---
 rtl/pwm8_capture_if.sv | 24 ++
 rtl/pwm8_capture.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pwm8_capture_if.sv
// Signal bundle between a PWM line source and the pwm8_capture block:
// the sampled line plus the measurement and stuck-line results.
interface pwm8_capture_if #(
  parameter int CNT_W = 9
);
  logic             pwm_in;
  logic [CNT_W-1:0] meas_high;
  logic [CNT_W-1:0] meas_period;
  logic             meas_valid;
  logic             stuck_hi;
  logic             stuck_lo;

  // master: the capture block (consumes the line, produces results)
  modport master (
    input  pwm_in,
    output meas_high, meas_period, meas_valid, stuck_hi, stuck_lo
  );

  // slave: whoever drives the line and consumes the results
  modport slave (
    output pwm_in,
    input  meas_high, meas_period, meas_valid, stuck_hi, stuck_lo
  );
endinterface

// File: rtl/pwm8_capture.sv
// PWM capture: synchronises a PWM line and measures high time and period of
// every frame in clk cycles, flagging a line that stays high or low too long.
module pwm8_capture #(
  parameter int CNT_W   = 9,
  parameter int TIMEOUT = 511   // must not exceed 2**CNT_W - 1
) (
  input  logic           clk,
  input  logic           rst,
  pwm8_capture_if.master cap
);

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic             s1, s2, s3;
  logic [1:0]       primed;
  logic             rise, fall, timeout;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d;
  logic             report, set_hi, set_lo;
  logic [CNT_W-1:0] meas_high_q, meas_period_q;
  logic             meas_valid_q, stuck_hi_q, stuck_lo_q;

  // primed[1] marks s2 as holding a real sample of pwm_in rather than its
  // reset value, so a line already high at reset release is never armed on.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      primed <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes its neighbour's pre-edge value;
      // blocking here would collapse the three stages into one.
      s1     <= cap.pwm_in;
      s2     <= s1;
      s3     <= s2;
      primed <= {primed[0], 1'b1};
    end
  end

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign timeout = (pcnt_q == TMO) && !rise && !fall;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d; a path that leaves
    // it unassigned would infer a latch.
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (primed[1] && !s2) state_d = ARMED;
        ARMED:   if (rise)             state_d = HIGH;
        HIGH:    if (fall)             state_d = LOW;
        LOW:     if (rise)             state_d = HIGH;
        default:                       state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hcnt_d = hcnt_q;
    pcnt_d = sat_inc(pcnt_q);
    report = 1'b0;
    set_hi = 1'b0;
    set_lo = 1'b0;
    if (timeout) begin
      pcnt_d = '0;
      set_hi = s2;
      set_lo = ~s2;
    end else begin
      case (state_q)
        ARMED: if (rise) begin
          hcnt_d = CNT_ONE;
          pcnt_d = CNT_ONE;
        end
        HIGH:  if (!fall) hcnt_d = sat_inc(hcnt_q);
        LOW:   if (rise) begin
          report = 1'b1;
          hcnt_d = CNT_ONE;
          pcnt_d = CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // A rise in LOW closes the frame: the counters still hold the full frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q        <= '0;
      pcnt_q        <= '0;
      meas_high_q   <= '0;
      meas_period_q <= '0;
      meas_valid_q  <= 1'b0;
      stuck_hi_q    <= 1'b0;
      stuck_lo_q    <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      pcnt_q       <= pcnt_d;
      meas_valid_q <= report;
      if (report) begin
        meas_high_q   <= hcnt_q;
        meas_period_q <= pcnt_q;
      end
      if (rise || fall) begin
        stuck_hi_q <= 1'b0;
        stuck_lo_q <= 1'b0;
      end else begin
        if (set_hi) stuck_hi_q <= 1'b1;
        if (set_lo) stuck_lo_q <= 1'b1;
      end
    end
  end

  assign cap.meas_high   = meas_high_q;
  assign cap.meas_period = meas_period_q;
  assign cap.meas_valid  = meas_valid_q;
  assign cap.stuck_hi    = stuck_hi_q;
  assign cap.stuck_lo    = stuck_lo_q;

endmodule
